// File: rtl/regbank_banco_if.sv
// Bus bundle for the register bank: write-back port, two read ports and the
// valid/ready debug dump link. The datapath/debug side uses master, the bank uses slave.
interface regbank_banco_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_addr_a;
    logic [ADDR_WIDTH-1:0] read_addr_b;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  dump_start;
    logic                  dump_ready;
    logic                  dump_valid;
    logic [ADDR_WIDTH-1:0] dump_addr;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_busy;
    logic                  dump_done;

    modport master (
        output write_enable, write_addr, write_data,
        output read_enable, read_addr_a, read_addr_b,
        output dump_start, dump_ready,
        input  data_a, data_b,
        input  dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  write_enable, write_addr, write_data,
        input  read_enable, read_addr_a, read_addr_b,
        input  dump_start, dump_ready,
        output data_a, data_b,
        output dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/regbank_banco.sv
// MIPS decode-stage register bank: 2**ADDR_WIDTH registers, two registered read
// ports with write-first bypass, one write port, and a streaming debug dump engine.
module regbank_banco #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic            clock,
    input  logic            reset,
    regbank_banco_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int NUM_PORTS = 3;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    logic [ADDR_WIDTH-1:0] port_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] port_value [NUM_PORTS];

    logic [DATA_WIDTH-1:0] data_a_reg;
    logic [DATA_WIDTH-1:0] data_b_reg;

    dump_state_t           state_reg, state_next;
    logic                  dump_valid_reg, dump_valid_next;
    logic [ADDR_WIDTH-1:0] dump_addr_reg, dump_addr_next;
    logic [DATA_WIDTH-1:0] dump_data_reg, dump_data_next;
    logic                  dump_busy_reg, dump_busy_next;
    logic                  dump_done_reg, dump_done_next;

    // Register 0 is never written, so it stays at its reset value of zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            always_ff @(posedge clock) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (bus.write_enable && (bus.write_addr != '0) &&
                             (bus.write_addr == ADDR_WIDTH'(gi))) begin
                    regs_reg[gi] <= bus.write_data;
                end
            end
        end
    endgenerate

    // Port 2 looks up the word the dump engine will present after the next transfer.
    assign port_addr[0] = bus.read_addr_a;
    assign port_addr[1] = bus.read_addr_b;
    assign port_addr[2] = dump_addr_reg + 1'b1;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_lookup
            always_comb begin
                port_value[gi] = regs_reg[port_addr[gi]];
                if (port_addr[gi] == '0) begin
                    port_value[gi] = '0;
                end else if (bus.write_enable && (bus.write_addr == port_addr[gi])) begin
                    port_value[gi] = bus.write_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            data_a_reg <= '0;
            data_b_reg <= '0;
        end else if (bus.read_enable) begin
            data_a_reg <= port_value[0];
            data_b_reg <= port_value[1];
        end
    end

    always_comb begin
        state_next      = state_reg;
        dump_valid_next = dump_valid_reg;
        dump_addr_next  = dump_addr_reg;
        dump_data_next  = dump_data_reg;
        dump_done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.dump_start) begin
                    state_next      = SEND;
                    dump_valid_next = 1'b1;
                    dump_addr_next  = '0;
                    dump_data_next  = '0;
                end
            end
            SEND: begin
                if (dump_valid_reg && bus.dump_ready) begin
                    if (dump_addr_reg == LAST_IDX) begin
                        state_next      = DONE;
                        dump_valid_next = 1'b0;
                        dump_done_next  = 1'b1;
                    end else begin
                        dump_addr_next = dump_addr_reg + 1'b1;
                        dump_data_next = port_value[2];
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next      = IDLE;
                dump_valid_next = 1'b0;
            end
        endcase
        dump_busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            dump_valid_reg <= 1'b0;
            dump_addr_reg  <= '0;
            dump_data_reg  <= '0;
            dump_busy_reg  <= 1'b0;
            dump_done_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dump_valid_reg <= dump_valid_next;
            dump_addr_reg  <= dump_addr_next;
            dump_data_reg  <= dump_data_next;
            dump_busy_reg  <= dump_busy_next;
            dump_done_reg  <= dump_done_next;
        end
    end

    assign bus.data_a     = data_a_reg;
    assign bus.data_b     = data_b_reg;
    assign bus.dump_valid = dump_valid_reg;
    assign bus.dump_addr  = dump_addr_reg;
    assign bus.dump_data  = dump_data_reg;
    assign bus.dump_busy  = dump_busy_reg;
    assign bus.dump_done  = dump_done_reg;
endmodule
